// File: rtl/aes_core_arbiter.sv
// Round-robin front end sharing one AES_CORE between two valid/ready requesters.
// Define AES_ARB_TIMEOUT_EN to enable the RUN-state watchdog (error response on expiry).
module aes_core_arbiter #(
  parameter int RST_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic         grant_id,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key,
  output logic         core_rst_n,
  input  logic [127:0] core_data_out,
  input  logic         core_finished
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef struct packed {
    logic [127:0] data;
    logic [127:0] key;
  } job_t;

  if (RST_CYCLES < 1 || RST_CYCLES > 15) begin : g_bad_rst_cycles
    $error("RST_CYCLES must be in 1..15");
  end
  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_t           state, state_nxt;
  logic             ptr;
  logic [3:0]       ld_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic [1:0]       req_vld, req_rdy, rsp_rdy;
  job_t [1:0]       req_job;
  logic             win, accept, first_run, fin_ok, timeout, retire;

  assign req_vld    = {req1_valid, req0_valid};
  assign rsp_rdy    = {rsp1_ready, rsp0_ready};
  assign req_job[0] = '{data: req0_data, key: req0_key};
  assign req_job[1] = '{data: req1_data, key: req1_key};

  // Pointer only breaks ties; a lone requester always wins.
  assign win     = (&req_vld) ? ptr : req_vld[1];
  assign req_rdy = (state == IDLE && |req_vld) ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign accept  = |req_rdy;

  assign req0_ready = req_rdy[0];
  assign req1_ready = req_rdy[1];

  // finished may still be high from the previous job in the first RUN cycle.
  assign first_run = (run_cnt == '0);
  assign fin_ok    = core_finished && !first_run;
  assign retire    = (state == DONE) && rsp_rdy[grant_id];

`ifdef AES_ARB_TIMEOUT_EN
  assign timeout = (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: if (ld_cnt == 4'(RST_CYCLES - 1)) state_nxt = RUN;
      RUN:  if (fin_ok || timeout) state_nxt = DONE;
      DONE: if (retire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      grant_id     <= 1'b0;
      core_data_in <= '0;
      core_key     <= '0;
      ld_cnt       <= '0;
      run_cnt      <= '0;
      rsp_data     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          grant_id     <= win;
          ptr          <= ~win;
          core_data_in <= req_job[win].data;
          core_key     <= req_job[win].key;
          ld_cnt       <= '0;
        end
        LOAD: begin
          ld_cnt  <= ld_cnt + 4'd1;
          run_cnt <= '0;
        end
        RUN: begin
          // Saturate so a long wait never wraps back into the stale-flag window.
          if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
          if (fin_ok) rsp_data <= core_data_out;
          else if (timeout) rsp_data <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (state == RUN) begin
      if (fin_ok) err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Core held in reset whenever no job is running; drops in the retirement cycle too.
  assign core_rst_n = (state == RUN) || (state == DONE && !retire);
  assign busy       = (state != IDLE);
  assign rsp0_valid = (state == DONE) && !grant_id;
  assign rsp1_valid = (state == DONE) &&  grant_id;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a small behavioural AES_CORE stand-in.
module tb_aes_core_arbiter;

  localparam int CORE_LAT = 3;
  localparam logic [127:0] FIPS_D = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_err, busy, grant_id;
  logic [127:0] core_data_in, core_key;
  logic         core_rst_n;
  logic [127:0] core_data_out = '0;
  logic         core_finished = 1'b0;

  int errs = 0;
  int checks = 0;
  logic stale_mode = 1'b0;
  logic never_fin = 1'b0;
  int lat_cnt = 0;

  always #5 clk = ~clk;

  aes_core_arbiter #(.RST_CYCLES(1), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id),
    .core_data_in(core_data_in), .core_key(core_key), .core_rst_n(core_rst_n),
    .core_data_out(core_data_out), .core_finished(core_finished)
  );

  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    if (d == FIPS_D && k == FIPS_K) return FIPS_C;
    return d ^ k ^ 128'h5a5a_0000_ffff_1234_a5a5_0000_ffff_4321;
  endfunction

  // Core stand-in: result CORE_LAT cycles after rst_n release. In stale mode the
  // finished flag survives reset and only clears on the first released clock.
  always @(posedge clk) begin
    if (!core_rst_n) begin
      lat_cnt <= 0;
      if (!stale_mode) core_finished <= 1'b0;
    end else begin
      if (stale_mode && lat_cnt == 0) core_finished <= 1'b0;
      if (lat_cnt == CORE_LAT - 1 && !never_fin) begin
        core_finished <= 1'b1;
        core_data_out <= core_fn(core_data_in, core_key);
      end
      lat_cnt <= lat_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input bit who, input logic [127:0] d, input logic [127:0] k);
    int n = 0;
    @(negedge clk);
    if (who) begin req1_valid = 1'b1; req1_data = d; req1_key = k; end
    else     begin req0_valid = 1'b1; req0_data = d; req0_key = k; end
    #1;
    while (!(who ? req1_ready : req0_ready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_wait", 128'(n < 50), 1);
    @(posedge clk); #1;
    if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("grant_id", grant_id, who);
  endtask

  // Call at accept edge + #1; returns cycles from accept to response valid.
  task automatic wait_rsp(input bit who, output int lat);
    lat = 0;
    while (!(who ? rsp1_valid : rsp0_valid) && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("rsp_wait", 128'(lat < 100), 1);
    chk("rsp_other_vld", who ? rsp0_valid : rsp1_valid, 0);
  endtask

  task automatic retire(input bit who);
    @(negedge clk);
    if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    #1;
    chk("ret_no_accept", {req1_ready, req0_ready}, 0);
    chk("ret_core_rstn", core_rst_n, 0);
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk("ret_busy", busy, 0);
    chk("ret_vld", {rsp1_valid, rsp0_valid}, 0);
  endtask

  initial begin
    int lat;
    logic [127:0] d0, k0, d1, k1;
    logic seen;

    // Reset values
    @(negedge clk); #1;
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_rsp_vld", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_misc", {rsp_err, busy, grant_id, core_rst_n}, 0);
    chk("rst_core_in", core_data_in, 0);
    chk("rst_core_key", core_key, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single job on requester 0 with the FIPS-197 vector
    issue(0, FIPS_D, FIPS_K);
    chk("load_rstn", core_rst_n, 0);
    chk("load_busy", busy, 1);
    wait_rsp(0, lat);
    chk("single_lat", lat, 5);
    chk("single_data", rsp_data, FIPS_C);
    chk("single_err", rsp_err, 0);
    retire(0);

    // Contention straight after reset: grants 0, 1, 0
    do_reset();
    d0 = 128'h1111; k0 = 128'h2222; d1 = 128'h3333; k1 = 128'h4444;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = d0; req0_key = k0;
    req1_valid = 1'b1; req1_data = d1; req1_key = k1;
    #1;
    chk("cont1_ready", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    chk("cont1_grant", grant_id, 0);
    req0_data = 128'h5555; req0_key = 128'h6666;
    chk("cont_busy_hold", {req1_ready, req0_ready}, 0);
    wait_rsp(0, lat);
    chk("cont1_data", rsp_data, core_fn(d0, k0));
    retire(0);
    chk("cont2_ready", {req1_ready, req0_ready}, 2'b10);
    @(posedge clk); #1;
    chk("cont2_grant", grant_id, 1);
    chk("cont2_key", core_key, k1);
    req1_data = 128'h7777; req1_key = 128'h8888;
    wait_rsp(1, lat);
    chk("cont2_data", rsp_data, core_fn(d1, k1));
    retire(1);
    chk("cont3_ready", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    chk("cont3_grant", grant_id, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(0, lat);
    chk("cont3_data", rsp_data, core_fn(128'h5555, 128'h6666));
    retire(0);

    // Backpressure on requester 1 while requester 0 waits
    d1 = 128'hdead_beef_0000_0001; k1 = 128'hcafe_f00d_0000_0002;
    issue(1, d1, k1);
    wait_rsp(1, lat);
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 128'h99; req0_key = 128'haa;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_data", rsp_data, core_fn(d1, k1));
      chk("bp_vld", {rsp1_valid, rsp0_valid}, 2'b10);
      chk("bp_key", core_key, k1);
      chk("bp_req0_rdy", req0_ready, 0);
    end
    retire(1);
    chk("bp_next_rdy", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("bp_next_grant", grant_id, 0);
    wait_rsp(0, lat);
    chk("bp_next_data", rsp_data, core_fn(128'h99, 128'haa));
    retire(0);

    // Stale finished flag carried across the restart
    stale_mode = 1'b1;
    issue(0, 128'h0a0a, 128'h0b0b);
    wait_rsp(0, lat);
    retire(0);
    issue(1, 128'h0c0c, 128'h0d0d);
    wait_rsp(1, lat);
    chk("stale_lat", lat, 5);
    chk("stale_data", rsp_data, core_fn(128'h0c0c, 128'h0d0d));
    retire(1);
    stale_mode = 1'b0;

    // Reset three cycles into RUN
    issue(0, 128'h1234, 128'h5678);
    @(posedge clk); #1;
    chk("mid_run_rstn", core_rst_n, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_pre", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rstn", core_rst_n, 0);
    chk("mid_busy", busy, 0);
    chk("mid_vld", {rsp1_valid, rsp0_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
    end
    chk("mid_dropped", seen, 0);
    issue(1, 128'h4321, 128'h8765);
    wait_rsp(1, lat);
    chk("mid_fresh_lat", lat, 5);
    chk("mid_fresh_data", rsp_data, core_fn(128'h4321, 128'h8765));
    retire(1);

`ifdef AES_ARB_TIMEOUT_EN
    // Watchdog: core never finishes
    never_fin = 1'b1;
    issue(0, 128'hfeed, 128'hface);
    wait_rsp(0, lat);
    chk("tmo_lat", lat, 17);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_data", rsp_data, 0);
    retire(0);
    never_fin = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time limit");
    $fatal(1, "time limit");
  end

endmodule
